instruction_fetch_queue: RTL and testbench

- Parametrised successor of the MIPS fetch stage. Decouples PC generation from decode through a DEPTH-entry instruction queue with a valid/ready handshake.
- Drives an external synchronous-read instruction memory with 1-cycle read latency and tracks in-flight reads.
- Squashes queued and in-flight wrong-path words on any redirect (branch, jump, register jump).
- Sits between the instruction RAM and the IF/ID boundary; decode stall becomes back-pressure instead of a PC enable.

---
 rtl/mips_fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/instruction_fetch_queue.sv | 99 +++++++++
 tb/tb_instruction_fetch_queue.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared constants for the instruction fetch queue: redirect source encodings
// and default reset/step values for the PC.
package mips_fetch_pkg;

    localparam logic [2:0] PC_SRC_SEQ    = 3'b000;
    localparam logic [2:0] PC_SRC_BRANCH = 3'b001;
    localparam logic [2:0] PC_SRC_JUMP   = 3'b010;
    localparam logic [2:0] PC_SRC_REG    = 3'b100;

    localparam int unsigned DEFAULT_RESET_PC = 0;
    localparam int unsigned DEFAULT_PC_STEP  = 1;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO holding {instruction, pc} pairs between instruction memory and decode.
// Head is read combinationally; clear empties the queue in one cycle.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (!push && pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Storage is reset too so the head reads zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: PC generation, 1-cycle-latency instruction memory interface and a
// decoupling queue toward decode, with squash of wrong-path words on redirect.
module instruction_fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int             len      = 32,
    parameter int             DEPTH    = 4,
    parameter logic [len-1:0] RESET_PC = len'(DEFAULT_RESET_PC),
    parameter logic [len-1:0] PC_STEP  = len'(DEFAULT_PC_STEP)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [2:0]     in_pc_src,
    input  logic [len-1:0] in_pc_jump,
    input  logic [len-1:0] in_pc_branch,
    input  logic [len-1:0] in_pc_register,
    output logic           out_imem_en,
    output logic [len-1:0] out_imem_addr,
    input  logic [len-1:0] in_imem_data,
    output logic           out_valid,
    input  logic           in_ready,
    output logic [len-1:0] out_instruction,
    output logic [len-1:0] out_pc,
    output logic [len-1:0] out_pc_next
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [len-1:0]   pc_q, pc_d;
    logic [len-1:0]   issued_pc_q, issued_pc_d;
    logic             inflight_q, inflight_d;
    logic             redirect, issue, push, pop;
    logic [len-1:0]   target;
    logic [CW-1:0]    fifo_count;
    logic             fifo_empty, fifo_full;
    logic [2*len-1:0] head;

    always_comb begin
        redirect = (in_pc_src != PC_SRC_SEQ);
        // Later assignments win: register > jump > branch.
        target = pc_q;
        if (|(in_pc_src & PC_SRC_BRANCH)) target = in_pc_branch;
        if (|(in_pc_src & PC_SRC_JUMP))   target = in_pc_jump;
        if (|(in_pc_src & PC_SRC_REG))    target = in_pc_register;

        // Credit counts queued plus in-flight words; a same-cycle pop earns nothing.
        issue = reset && !redirect && ((fifo_count + CW'(inflight_q)) < CW'(DEPTH));
        push  = inflight_q && !redirect;
        out_valid = !fifo_empty && !redirect;
        pop   = out_valid && in_ready;

        pc_d        = pc_q;
        issued_pc_d = issued_pc_q;
        inflight_d  = issue;
        if (redirect) begin
            pc_d = target;
        end else if (issue) begin
            pc_d        = pc_q + PC_STEP;
            issued_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q        <= RESET_PC;
            issued_pc_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            issued_pc_q <= issued_pc_d;
            inflight_q  <= inflight_d;
        end
    end

    fetch_fifo #(
        .WIDTH (2 * len),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .pop       (pop),
        .clear     (redirect),
        .push_data ({in_imem_data, issued_pc_q}),
        .head_data (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    no_overflow_a: assert property (@(posedge clk) disable iff (!reset) !(push && fifo_full));

    assign out_imem_en     = issue;
    assign out_imem_addr   = pc_q;
    assign out_instruction = head[2*len-1:len];
    assign out_pc          = head[len-1:0];
    assign out_pc_next     = head[len-1:0] + PC_STEP;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue: queue-based reference model
// compared every cycle, plus directed literal expectations per scenario.
module tb_instruction_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        reset;
    logic [2:0]  in_pc_src;
    logic [31:0] in_pc_jump, in_pc_branch, in_pc_register;
    logic        out_imem_en;
    logic [31:0] out_imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        in_ready;
    logic [31:0] out_instruction, out_pc, out_pc_next;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: PCs waiting in the queue, plus the word in flight.
    logic [31:0] m_q[$];
    logic        m_inflight;
    logic [31:0] m_pc;
    logic [31:0] m_iaddr;

    instruction_fetch_queue #(
        .len      (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .PC_STEP  (32'h1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_pc_src       (in_pc_src),
        .in_pc_jump      (in_pc_jump),
        .in_pc_branch    (in_pc_branch),
        .in_pc_register  (in_pc_register),
        .out_imem_en     (out_imem_en),
        .out_imem_addr   (out_imem_addr),
        .in_imem_data    (imem_rdata),
        .out_valid       (out_valid),
        .in_ready        (in_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .out_pc_next     (out_pc_next)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000_0000 + addr;
    endfunction

    // Synchronous-read instruction memory, one cycle latency.
    always @(posedge clk) begin
        if (out_imem_en) imem_rdata <= mem_word(out_imem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_inflight = 1'b0;
            m_pc       = RESET_PC;
        end else begin
            logic redir;
            logic en;
            redir = (in_pc_src != 3'b000);
            en    = !redir && (m_q.size() + int'(m_inflight) < DEPTH);
            if (redir) begin
                m_q.delete();
                m_inflight = 1'b0;
                m_pc = in_pc_src[2] ? in_pc_register :
                       in_pc_src[1] ? in_pc_jump : in_pc_branch;
            end else begin
                if (m_q.size() > 0 && in_ready) void'(m_q.pop_front());
                if (m_inflight) m_q.push_back(m_iaddr);
                m_inflight = en;
                if (en) begin
                    m_iaddr = m_pc;
                    m_pc    = m_pc + 32'd1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            check("rst_valid", {31'b0, out_valid}, 32'd0);
            check("rst_en", {31'b0, out_imem_en}, 32'd0);
            check("rst_addr", out_imem_addr, RESET_PC);
            check("rst_pc", out_pc, 32'd0);
            check("rst_instr", out_instruction, 32'd0);
        end else begin
            logic redir;
            logic exp_en;
            logic exp_valid;
            redir     = (in_pc_src != 3'b000);
            exp_en    = !redir && (m_q.size() + int'(m_inflight) < DEPTH);
            exp_valid = !redir && (m_q.size() > 0);
            check("imem_en", {31'b0, out_imem_en}, {31'b0, exp_en});
            check("imem_addr", out_imem_addr, m_pc);
            check("valid", {31'b0, out_valid}, {31'b0, exp_valid});
            if (exp_valid) begin
                check("head_pc", out_pc, m_q[0]);
                check("head_instr", out_instruction, mem_word(m_q[0]));
                check("head_pc_next", out_pc_next, m_q[0] + 32'd1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input int n, input logic inf, input string name);
        int k = 0;
        while (!(m_q.size() == n && m_inflight == inf) && k < 30) begin
            step();
            k++;
        end
        check(name, {31'b0, (k < 30)}, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        in_pc_src = 3'b000;
        in_pc_jump = '0;
        in_pc_branch = '0;
        in_pc_register = '0;
        in_ready = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);

        // Reset release: issue cycle 0, valid cycle 2, one per cycle.
        #1 reset = 1'b1;
        #1 check("c0_en", {31'b0, out_imem_en}, 32'd1);
        check("c0_addr", out_imem_addr, 32'd0);
        step(); #1 check("c1_valid", {31'b0, out_valid}, 32'd0);
        step(); #1 check("c2_valid", {31'b0, out_valid}, 32'd1);
        check("c2_pc", out_pc, 32'd0);
        check("c2_instr", out_instruction, 32'h1000_0000);
        check("c2_pc_next", out_pc_next, 32'd1);

        // Stall for 10 cycles from cycle 3: queue fills, head holds.
        step(); in_ready = 1'b0;
        #1 check("c3_pc", out_pc, 32'd1);
        repeat (10) step();
        #1 check("stall_en", {31'b0, out_imem_en}, 32'd0);
        check("stall_valid", {31'b0, out_valid}, 32'd1);
        check("stall_pc", out_pc, 32'd1);
        check("stall_instr", out_instruction, 32'h1000_0001);
        in_ready = 1'b1;
        step(); #1 check("release_pc", out_pc, 32'd2);

        // Jump with 3 queued and 1 in flight.
        in_ready = 1'b0;
        wait_state(3, 1'b1, "reach_3q_1f");
        in_pc_src = 3'b010; in_pc_jump = 32'h40; in_ready = 1'b1;
        #1 check("jmp_valid_t0", {31'b0, out_valid}, 32'd0);
        check("jmp_en_t0", {31'b0, out_imem_en}, 32'd0);
        step(); in_pc_src = 3'b000;
        #1 check("jmp_valid_t1", {31'b0, out_valid}, 32'd0);
        check("jmp_addr_t1", out_imem_addr, 32'h40);
        step(); #1 check("jmp_valid_t2", {31'b0, out_valid}, 32'd0);
        step(); #1 check("jmp_pc_t3", out_pc, 32'h40);
        check("jmp_instr_t3", out_instruction, 32'h1000_0040);
        step(); #1 check("jmp_pc_t4", out_pc, 32'h41);

        // All three sources at once: register target wins.
        in_pc_src = 3'b111; in_pc_register = 32'h80; in_pc_jump = 32'h40; in_pc_branch = 32'h20;
        step(); in_pc_src = 3'b000;
        step();
        step(); #1 check("prio_pc", out_pc, 32'h80);
        check("prio_instr", out_instruction, 32'h1000_0080);

        // PC wraps modulo 2^32.
        in_pc_src = 3'b010; in_pc_jump = 32'hFFFF_FFFE;
        step(); in_pc_src = 3'b000;
        step();
        step(); #1 check("wrap_pc0", out_pc, 32'hFFFF_FFFE);
        step(); #1 check("wrap_pc1", out_pc, 32'hFFFF_FFFF);
        check("wrap_pc_next", out_pc_next, 32'h0);
        step(); #1 check("wrap_pc2", out_pc, 32'h0);

        // Asynchronous reset mid-stream with 2 queued and 1 in flight.
        in_ready = 1'b0;
        wait_state(2, 1'b1, "reach_2q_1f");
        reset = 1'b0;
        #1 check("arst_valid", {31'b0, out_valid}, 32'd0);
        check("arst_en", {31'b0, out_imem_en}, 32'd0);
        check("arst_pc", out_pc, 32'd0);
        check("arst_instr", out_instruction, 32'd0);
        in_ready = 1'b1;
        step();
        step(); reset = 1'b1;
        #1 check("rr_c0_en", {31'b0, out_imem_en}, 32'd1);
        check("rr_c0_addr", out_imem_addr, RESET_PC);
        step(); #1 check("rr_c1_valid", {31'b0, out_valid}, 32'd0);
        step(); #1 check("rr_c2_valid", {31'b0, out_valid}, 32'd1);
        check("rr_c2_pc", out_pc, RESET_PC);
        check("rr_c2_instr", out_instruction, 32'h1000_0000);
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
